// File: rtl/keyspace_scheduler.sv
// keyspace_scheduler: hands out candidate-index chunks to two MD5 cores and serialises their hit reports
// Ports: clock/reset (sync, active-high); start/rewind/key_limit control the search;
// core_start_i/core_base_i/core_end_i dispatch a chunk to core i; core_done_i/core_hit_i/core_hit_key_i
// return its result; rep_valid/rep_ready/rep_key/rep_core form the report stream; running/done/found are status.
module keyspace_scheduler #(
    parameter int KEY_WIDTH  = 48,
    parameter int CHUNK_LOG2 = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 rewind,
    input  logic [KEY_WIDTH-1:0] key_limit,
    output logic                 core_start_0,
    output logic [KEY_WIDTH-1:0] core_base_0,
    output logic [KEY_WIDTH-1:0] core_end_0,
    input  logic                 core_done_0,
    input  logic                 core_hit_0,
    input  logic [KEY_WIDTH-1:0] core_hit_key_0,
    output logic                 core_start_1,
    output logic [KEY_WIDTH-1:0] core_base_1,
    output logic [KEY_WIDTH-1:0] core_end_1,
    input  logic                 core_done_1,
    input  logic                 core_hit_1,
    input  logic [KEY_WIDTH-1:0] core_hit_key_1,
    output logic                 rep_valid,
    input  logic                 rep_ready,
    output logic [KEY_WIDTH-1:0] rep_key,
    output logic                 rep_core,
    output logic                 running,
    output logic                 done,
    output logic                 found
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [KEY_WIDTH:0] CHUNK = (KEY_WIDTH+1)'(1) << CHUNK_LOG2;
    state_t state, state_nxt;
    logic [KEY_WIDTH-1:0] limit, next_base, chunk_end, buf_key_0, buf_key_1, key_nxt_0, key_nxt_1;
    logic [KEY_WIDTH:0] sum;
    logic [1:0] active, full, cd, ch, elig, disp, load, free, full_nxt, act_nxt;
    logic has_work, exhausted, in_run, hs, last, sel;
    always_comb begin
        cd = {core_done_1, core_done_0} & active;
        ch = {core_hit_1, core_hit_0};
        in_run = state == RUN;
        sum = {1'b0, next_base} + CHUNK;
        // a carry past KEY_WIDTH is caught by the wide compare and clamps to the limit
        chunk_end = (sum >= {1'b0, limit}) ? limit : sum[KEY_WIDTH-1:0];
        has_work = next_base < limit;
        // a core finishing without a hit this cycle is already free for the next chunk
        elig = {2{in_run & ~rewind & has_work}} & ~full & (~active | (cd & ~ch));
        disp = {elig[1] & ~elig[0], elig[0]};
        act_nxt = (active & ~cd) | disp;
        load = {2{in_run}} & cd & ch;
        hs = rep_valid & rep_ready;
        free = {hs & rep_core, hs & ~rep_core};
        full_nxt = (full & ~free) | load;
        key_nxt_0 = load[0] ? core_hit_key_0 : buf_key_0;
        key_nxt_1 = load[1] ? core_hit_key_1 : buf_key_1;
        // round-robin: prefer the core that was not served last
        sel = last ? ~full_nxt[0] : full_nxt[1];
        exhausted = ~has_work & ~|active & ~|full;
        state_nxt = state;
        if (rewind)
            state_nxt = (state == DRAIN || (in_run && |act_nxt)) ? DRAIN : IDLE;
        else if (state == IDLE && start)
            state_nxt = RUN;
        else if (in_run && exhausted)
            state_nxt = DONE;
        else if (state == DRAIN && ~|act_nxt)
            state_nxt = IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            limit <= '0;
            next_base <= '0;
            active <= '0;
            full <= '0;
            buf_key_0 <= '0;
            buf_key_1 <= '0;
            last <= 1'b1;
            core_start_0 <= 1'b0;
            core_start_1 <= 1'b0;
            core_base_0 <= '0;
            core_base_1 <= '0;
            core_end_0 <= '0;
            core_end_1 <= '0;
            rep_valid <= 1'b0;
            rep_key <= '0;
            rep_core <= 1'b0;
            running <= 1'b0;
            done <= 1'b0;
            found <= 1'b0;
        end else begin
            state <= state_nxt;
            running <= state_nxt == RUN || state_nxt == DRAIN;
            done <= state_nxt == DONE;
            core_start_0 <= disp[0];
            core_start_1 <= disp[1];
            if (disp[0]) begin
                core_base_0 <= next_base;
                core_end_0 <= chunk_end;
            end
            if (disp[1]) begin
                core_base_1 <= next_base;
                core_end_1 <= chunk_end;
            end
            if (|disp)
                next_base <= chunk_end;
            active <= act_nxt;
            full <= full_nxt;
            buf_key_0 <= key_nxt_0;
            buf_key_1 <= key_nxt_1;
            if (|load)
                found <= 1'b1;
            if (~rep_valid || rep_ready) begin
                rep_valid <= |full_nxt;
                rep_core <= sel;
                rep_key <= sel ? key_nxt_1 : key_nxt_0;
                if (|full_nxt)
                    last <= sel;
            end
            if (state == IDLE && start) begin
                limit <= key_limit;
                next_base <= '0;
                found <= 1'b0;
            end
            if (rewind) begin
                full <= '0;
                next_base <= '0;
                found <= 1'b0;
                rep_valid <= 1'b0;
            end
        end
    end
endmodule
